rat_multi: RTL and testbench

Parametrised register alias table for the rename stage. It holds a speculative map and an architectural map from architectural registers (AR) to physical registers (PR). Up to `WIDTH` rename lanes look up sources and old destinations and write new mappings each cycle; up to `WIDTH` retire lanes update the architectural map. A flush restores the speculative map from the architectural map, and optional checkpoints allow branch-level recovery.

---
 rtl/rat_multi.sv | 187 ++++++++++++++++++
 tb/tb_rat_multi.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/rat_multi.sv
// rat_multi: register alias table for a WIDTH-wide rename stage.
//
// Holds a speculative map and an architectural map (AR -> PR). Rename lanes
// look up sources/old destinations with an in-group bypass and write new
// mappings. Retire lanes update the architectural map. A flush copies the
// architectural map (after this cycle's retires) into the speculative map.
//
// Optional feature macro: RAT_CKPT_EN
//   defined   : NUM_CKPT checkpoint slots, ckpt_take snapshots the speculative
//               map after lanes 0..ckpt_take_lane, ckpt_restore reloads a slot.
//   undefined : no checkpoint storage; all ckpt_* inputs are ignored.
//
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   ren_dest_en/ar/pr            per-lane destination write
//   ren_src_ar / ren_src_pr      two source lookups per lane (slots 2i, 2i+1)
//   ren_old_pr                   prior mapping of each lane's destination AR
//   ret_dest_en/ar/pr            per-lane architectural commit
//   flush                        recover speculative map from architectural
//   spec_busy                    registered, bit a = spec[a] != arch[a]
//   ckpt_take/_id/_lane          checkpoint snapshot request
//   ckpt_restore/_id             checkpoint restore request
module rat_multi #(
  parameter int AR_NUM   = 32,
  parameter int PR_W     = 7,
  parameter int WIDTH    = 4,
  parameter int NUM_CKPT = 4,
  localparam int ARW     = $clog2(AR_NUM),
  localparam int CKW     = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1,
  localparam int LW      = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [WIDTH-1:0]        ren_dest_en,
  input  logic [WIDTH*ARW-1:0]    ren_dest_ar,
  input  logic [WIDTH*PR_W-1:0]   ren_dest_pr,
  input  logic [2*WIDTH*ARW-1:0]  ren_src_ar,
  output logic [2*WIDTH*PR_W-1:0] ren_src_pr,
  output logic [WIDTH*PR_W-1:0]   ren_old_pr,
  input  logic [WIDTH-1:0]        ret_dest_en,
  input  logic [WIDTH*ARW-1:0]    ret_dest_ar,
  input  logic [WIDTH*PR_W-1:0]   ret_dest_pr,
  input  logic                    flush,
  output logic [AR_NUM-1:0]       spec_busy,
  input  logic                    ckpt_take,
  input  logic [CKW-1:0]          ckpt_take_id,
  input  logic [LW-1:0]           ckpt_take_lane,
  input  logic                    ckpt_restore,
  input  logic [CKW-1:0]          ckpt_restore_id
);

  logic [PR_W-1:0] spec_map [AR_NUM];
  logic [PR_W-1:0] arch_map [AR_NUM];
  logic [PR_W-1:0] ren_nxt  [AR_NUM];
  logic [PR_W-1:0] arch_nxt [AR_NUM];
  logic [PR_W-1:0] spec_nxt [AR_NUM];
  logic [AR_NUM-1:0] busy_nxt;

  // Source lookup: a lane sees only strictly lower lanes; the highest
  // matching lower lane wins because later loop iterations overwrite.
  always_comb begin
    logic [ARW-1:0]  ar;
    logic [PR_W-1:0] pr;
    ren_src_pr = '0;
    for (int s = 0; s < 2*WIDTH; s++) begin
      ar = ren_src_ar[s*ARW +: ARW];
      pr = spec_map[ar];
      for (int j = 0; j < s/2; j++) begin
        if (ren_dest_en[j] && (ren_dest_ar[j*ARW +: ARW] == ar))
          pr = ren_dest_pr[j*PR_W +: PR_W];
      end
      if (ar == '0)
        pr = '0;
      ren_src_pr[s*PR_W +: PR_W] = pr;
    end
  end

  always_comb begin
    logic [ARW-1:0]  ar;
    logic [PR_W-1:0] pr;
    ren_old_pr = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ar = ren_dest_ar[i*ARW +: ARW];
      pr = spec_map[ar];
      for (int j = 0; j < i; j++) begin
        if (ren_dest_en[j] && (ren_dest_ar[j*ARW +: ARW] == ar))
          pr = ren_dest_pr[j*PR_W +: PR_W];
      end
      if (ar == '0)
        pr = '0;
      ren_old_pr[i*PR_W +: PR_W] = pr;
    end
  end

  // In-order application, so the highest lane writing an AR wins.
  always_comb begin
    ren_nxt = spec_map;
    for (int i = 0; i < WIDTH; i++) begin
      if (ren_dest_en[i] && (ren_dest_ar[i*ARW +: ARW] != '0))
        ren_nxt[ren_dest_ar[i*ARW +: ARW]] = ren_dest_pr[i*PR_W +: PR_W];
    end
  end

  always_comb begin
    arch_nxt = arch_map;
    for (int i = 0; i < WIDTH; i++) begin
      if (ret_dest_en[i] && (ret_dest_ar[i*ARW +: ARW] != '0))
        arch_nxt[ret_dest_ar[i*ARW +: ARW]] = ret_dest_pr[i*PR_W +: PR_W];
    end
  end

`ifdef RAT_CKPT_EN
  logic [PR_W-1:0] ckpt_mem  [NUM_CKPT][AR_NUM];
  logic [PR_W-1:0] ckpt_snap [AR_NUM];
  logic            restore_act;
  logic            take_act;

  // Flush overrides everything; any restore drops a same-cycle take.
  assign restore_act = ckpt_restore && !flush;
  assign take_act    = ckpt_take && !flush && !ckpt_restore;

  // Partial application of the rename group up to and including the
  // requested lane, so the snapshot sits exactly at the branch boundary.
  always_comb begin
    logic [PR_W-1:0] cum [AR_NUM];
    cum       = spec_map;
    ckpt_snap = spec_map;
    for (int i = 0; i < WIDTH; i++) begin
      if (ren_dest_en[i] && (ren_dest_ar[i*ARW +: ARW] != '0))
        cum[ren_dest_ar[i*ARW +: ARW]] = ren_dest_pr[i*PR_W +: PR_W];
      if (ckpt_take_lane == LW'(i))
        ckpt_snap = cum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CKPT; c++)
        for (int a = 0; a < AR_NUM; a++)
          ckpt_mem[c][a] <= PR_W'(a);
    end else if (take_act) begin
      ckpt_mem[ckpt_take_id] <= ckpt_snap;
    end
  end

  always_comb begin
    if (flush)
      spec_nxt = arch_nxt;
    else if (restore_act)
      spec_nxt = ckpt_mem[ckpt_restore_id];
    else
      spec_nxt = ren_nxt;
  end
`else
  logic unused_ckpt;
  assign unused_ckpt = ^{ckpt_take, ckpt_take_id, ckpt_take_lane,
                         ckpt_restore, ckpt_restore_id};

  always_comb begin
    if (flush)
      spec_nxt = arch_nxt;
    else
      spec_nxt = ren_nxt;
  end
`endif

  always_comb begin
    busy_nxt = '0;
    for (int a = 1; a < AR_NUM; a++)
      busy_nxt[a] = (spec_nxt[a] != arch_nxt[a]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int a = 0; a < AR_NUM; a++) begin
        spec_map[a] <= PR_W'(a);
        arch_map[a] <= PR_W'(a);
      end
      spec_busy <= '0;
    end else begin
      spec_map  <= spec_nxt;
      arch_map  <= arch_nxt;
      spec_busy <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_rat_multi.sv
module tb_rat_multi;
  localparam int AR_NUM = 32;
  localparam int PR_W   = 7;
  localparam int WIDTH  = 4;
  localparam int ARW    = 5;
  localparam int CKW    = 2;
  localparam int LW     = 2;

  logic                    clk;
  logic                    rst_n;
  logic [WIDTH-1:0]        ren_dest_en;
  logic [WIDTH*ARW-1:0]    ren_dest_ar;
  logic [WIDTH*PR_W-1:0]   ren_dest_pr;
  logic [2*WIDTH*ARW-1:0]  ren_src_ar;
  logic [2*WIDTH*PR_W-1:0] ren_src_pr;
  logic [WIDTH*PR_W-1:0]   ren_old_pr;
  logic [WIDTH-1:0]        ret_dest_en;
  logic [WIDTH*ARW-1:0]    ret_dest_ar;
  logic [WIDTH*PR_W-1:0]   ret_dest_pr;
  logic                    flush;
  logic [AR_NUM-1:0]       spec_busy;
  logic                    ckpt_take;
  logic [CKW-1:0]          ckpt_take_id;
  logic [LW-1:0]           ckpt_take_lane;
  logic                    ckpt_restore;
  logic [CKW-1:0]          ckpt_restore_id;

  int vectors = 0;
  int miscompares = 0;

  rat_multi dut (
    .clk(clk), .rst_n(rst_n),
    .ren_dest_en(ren_dest_en), .ren_dest_ar(ren_dest_ar), .ren_dest_pr(ren_dest_pr),
    .ren_src_ar(ren_src_ar), .ren_src_pr(ren_src_pr), .ren_old_pr(ren_old_pr),
    .ret_dest_en(ret_dest_en), .ret_dest_ar(ret_dest_ar), .ret_dest_pr(ret_dest_pr),
    .flush(flush), .spec_busy(spec_busy),
    .ckpt_take(ckpt_take), .ckpt_take_id(ckpt_take_id), .ckpt_take_lane(ckpt_take_lane),
    .ckpt_restore(ckpt_restore), .ckpt_restore_id(ckpt_restore_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    ren_dest_en = '0; ren_dest_ar = '0; ren_dest_pr = '0; ren_src_ar = '0;
    ret_dest_en = '0; ret_dest_ar = '0; ret_dest_pr = '0; flush = 1'b0;
    ckpt_take = 1'b0; ckpt_take_id = '0; ckpt_take_lane = '0;
    ckpt_restore = 1'b0; ckpt_restore_id = '0;
  endtask

  task automatic set_ren(input int lane, input int ar, input int pr);
    ren_dest_en[lane] = 1'b1;
    ren_dest_ar[lane*ARW +: ARW] = ARW'(ar);
    ren_dest_pr[lane*PR_W +: PR_W] = PR_W'(pr);
  endtask

  task automatic set_ret(input int lane, input int ar, input int pr);
    ret_dest_en[lane] = 1'b1;
    ret_dest_ar[lane*ARW +: ARW] = ARW'(ar);
    ret_dest_pr[lane*PR_W +: PR_W] = PR_W'(pr);
  endtask

  task automatic set_src(input int slot, input int ar);
    ren_src_ar[slot*ARW +: ARW] = ARW'(ar);
  endtask

  function automatic logic [31:0] src_pr(input int slot);
    return 32'(ren_src_pr[slot*PR_W +: PR_W]);
  endfunction

  function automatic logic [31:0] old_pr(input int lane);
    return 32'(ren_old_pr[lane*PR_W +: PR_W]);
  endfunction

  // Clock the current inputs in, then return to idle inputs.
  task automatic tick();
    @(posedge clk);
    #1;
    clear_inputs();
    #1;
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    #12;
    check("reset_busy", spec_busy, 32'h0);
    rst_n = 1'b1;
    set_src(0, 5);
    set_src(1, 31);
    #1;
    check("reset_ar5", src_pr(0), 32'd5);
    check("reset_ar31", src_pr(1), 32'd31);

    // Same-cycle bypass with highest-lower-lane priority.
    set_ren(0, 3, 40);
    set_ren(2, 3, 41);
    ren_dest_ar[3*ARW +: ARW] = 5'd3;
    set_src(4, 3);
    set_src(6, 3);
    #1;
    check("byp_lane3", src_pr(6), 32'd41);
    check("byp_lane2_no_self", src_pr(4), 32'd40);
    check("old_lane0", old_pr(0), 32'd3);
    check("old_lane2", old_pr(2), 32'd40);
    check("old_lane3", old_pr(3), 32'd41);
    tick();
    set_src(0, 3);
    #1;
    check("ar3_after", src_pr(0), 32'd41);
    check("busy_ar3", spec_busy, 32'h0000_0008);

    // Rename then retire AR7.
    set_ren(1, 7, 50);
    tick();
    check("busy_ar7_set", spec_busy, 32'h0000_0088);
    set_ret(2, 7, 50);
    tick();
    check("busy_ar7_clr", spec_busy, 32'h0000_0008);

    // Rename and retire AR9 in the same cycle with different PRs.
    set_ren(0, 9, 60);
    set_ret(0, 9, 55);
    tick();
    set_src(0, 9);
    #1;
    check("ar9_spec", src_pr(0), 32'd60);
    check("busy_ar9", spec_busy, 32'h0000_0208);
    flush = 1'b1;
    tick();
    set_src(0, 9);
    set_src(1, 3);
    #1;
    check("flush_ar9", src_pr(0), 32'd55);
    check("flush_ar3", src_pr(1), 32'd3);
    check("flush_busy", spec_busy, 32'h0);

    // Flush with same-cycle retires (priority on AR10); rename ignored.
    flush = 1'b1;
    set_ret(0, 11, 22);
    set_ret(1, 10, 20);
    set_ret(3, 10, 21);
    set_ren(0, 13, 44);
    tick();
    set_src(0, 10);
    set_src(1, 11);
    set_src(2, 13);
    #1;
    check("flush_ret_ar10", src_pr(0), 32'd21);
    check("flush_ret_ar11", src_pr(1), 32'd22);
    check("flush_ren_ign", src_pr(2), 32'd13);
    check("flush_ret_busy", spec_busy, 32'h0);

    // AR0 is hard-wired.
    set_ren(0, 0, 70);
    set_src(2, 0);
    #1;
    check("ar0_no_bypass", src_pr(2), 32'd0);
    tick();
    set_src(0, 0);
    #1;
    check("ar0_lookup", src_pr(0), 32'd0);
    check("ar0_busy", spec_busy, 32'h0);

    // Checkpoint at lane 1, then a later rename, then restore.
    set_ren(1, 4, 80);
    set_ren(2, 4, 81);
    ckpt_take = 1'b1;
    ckpt_take_id = 2'd2;
    ckpt_take_lane = 2'd1;
    tick();
    set_src(0, 4);
    #1;
    check("ckpt_ar4_spec", src_pr(0), 32'd81);
    check("ckpt_busy", spec_busy, 32'h0000_0010);
    set_ren(0, 12, 33);
    tick();
    ckpt_restore = 1'b1;
    ckpt_restore_id = 2'd2;
    tick();
    set_src(0, 4);
    set_src(1, 12);
    #1;
`ifdef RAT_CKPT_EN
    check("restore_ar4", src_pr(0), 32'd80);
    check("restore_ar12", src_pr(1), 32'd12);
    check("restore_busy", spec_busy, 32'h0000_0010);
`else
    check("restore_ar4", src_pr(0), 32'd81);
    check("restore_ar12", src_pr(1), 32'd33);
    check("restore_busy", spec_busy, 32'h0000_1010);
`endif

    // Asynchronous reset mid-cycle.
    #2;
    rst_n = 1'b0;
    #1;
    set_src(0, 4);
    #1;
    check("arst_busy", spec_busy, 32'h0);
    check("arst_ar4", src_pr(0), 32'd4);
    rst_n = 1'b1;
    #10;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
